// File: rtl/decoder_pkg.sv
// Shared encodings for the 2-to-4 decoder / scanner: state codes, the blank
// pattern and the active-low one-hot decode map.
package decoder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t MANUAL = 2'd1;
  localparam state_t SCAN   = 2'd2;

  localparam logic [3:0] LED_OFF = 4'b1111;

  // Exactly one bit low, at the position named by the code.
  function automatic logic [3:0] decode2_4(input logic [1:0] code);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << code;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/decoder2_4_scan_tick_gen.sv
// Free-running prescaler for the scan pacing; tick marks the last count of
// each DIV-cycle dwell.
module tick_gen #(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/decoder2_4_scan.sv
// Active-low one-hot select driver: manual decode of SW, or an automatic walk
// over the four select lines paced by tick_gen. All outputs are registered.
module decoder2_4_scan
  import decoder_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic [1:0] SW,
  output logic [3:0] LED,
  output logic [1:0] code,
  output logic       step
);

  state_t     state;
  state_t     next_state;
  logic [1:0] index;
  logic [1:0] index_next;
  logic       scan_run;
  logic       clr;
  logic       tick;

  always_comb begin
    next_state = IDLE;
    if (en) begin
      next_state = mode ? SCAN : MANUAL;
    end
  end

  // The prescaler only runs while SCAN persists across an edge; entry and
  // every non-scan cycle restart it so each dwell is a full DIV cycles.
  assign scan_run   = (state == SCAN) && (next_state == SCAN);
  assign clr        = !scan_run;
  assign index_next = index + 2'd1;

  tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= 2'd0;
      LED   <= LED_OFF;
      code  <= 2'd0;
      step  <= 1'b0;
    end else begin
      state <= next_state;
      step  <= 1'b0;
      case (next_state)
        MANUAL: begin
          index <= 2'd0;
          LED   <= decode2_4(SW);
          code  <= SW;
        end
        SCAN: begin
          if (state != SCAN) begin
            index <= 2'd0;
            LED   <= decode2_4(2'd0);
            code  <= 2'd0;
          end else if (tick) begin
            index <= index_next;
            LED   <= decode2_4(index_next);
            code  <= index_next;
            step  <= 1'b1;
          end
        end
        default: begin
          index <= 2'd0;
          LED   <= LED_OFF;
          code  <= 2'd0;
        end
      endcase
    end
  end

  // Output invariants that must hold whatever the input sequence.
  a_led_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(~LED));
  a_led_matches_code : assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE) |-> (LED == decode2_4(code)));
  a_step_only_in_scan : assert property (@(posedge clk) disable iff (!rst_n)
    step |-> (state == SCAN));

endmodule

// File: tb/tb_decoder2_4_scan.sv
// Directed bench for decoder2_4_scan: one DIV=4 instance and one DIV=1
// instance driven by the same inputs, checked against hand-derived values.
module tb_decoder2_4_scan;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [1:0] sw;

  logic [3:0] led4;
  logic [1:0] code4;
  logic       step4;
  logic [3:0] led1;
  logic [1:0] code1;
  logic       step1;

  int vectors;
  int miscompares;

  logic [3:0] led_tab [4];

  decoder2_4_scan #(.DIV(4), .CNT_W(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .SW    (sw),
    .LED   (led4),
    .code  (code4),
    .step  (step4)
  );

  decoder2_4_scan #(.DIV(1), .CNT_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .SW    (sw),
    .LED   (led1),
    .code  (code1),
    .step  (step1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board-side 4-to-2 priority encoder on the active-low bus.
  function automatic logic [1:0] encode4_2(input logic [3:0] bus);
    casez (bus)
      4'b???0: return 2'd0;
      4'b??01: return 2'd1;
      4'b?011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic apply_stimulus(input logic r, input logic e, input logic m, input logic [1:0] s);
    rst_n = r;
    en    = e;
    mode  = m;
    sw    = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag,
                              input logic [3:0] led_obs, input logic [1:0] code_obs, input logic step_obs,
                              input logic [3:0] led_exp, input logic [1:0] code_exp, input logic step_exp);
    vectors++;
    assert ({led_obs, code_obs, step_obs} === {led_exp, code_exp, step_exp}) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed LED=%b code=%0d step=%b, expected LED=%b code=%0d step=%b",
             tag, led_obs, code_obs, step_obs, led_exp, code_exp, step_exp);
    end
  endtask

  // t counts edges since SCAN entry; index k shows for t = 4k..4k+3 and
  // step fires on the edge that changes the index.
  task automatic scan_dwell4(input string tag, input int first_t, input int last_t);
    for (int t = first_t; t <= last_t; t++) begin
      next_cycle();
      check_output($sformatf("%s_t%0d", tag, t), led4, code4, step4,
                   led_tab[(t / 4) % 4], 2'((t / 4) % 4), (t % 4) == 0);
    end
  endtask

  initial begin
    logic [3:0] exp_led;
    vectors     = 0;
    miscompares = 0;
    led_tab[0]  = 4'b1110;
    led_tab[1]  = 4'b1101;
    led_tab[2]  = 4'b1011;
    led_tab[3]  = 4'b0111;

    // Reset wins over en=1/mode=1
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_output($sformatf("reset_c%0d", i), led4, code4, step4, 4'b1111, 2'd0, 1'b0);
    end
    check_output("reset_div1", led1, code1, step1, 4'b1111, 2'd0, 1'b0);

    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd0);
    next_cycle();
    check_output("entry_div4", led4, code4, step4, 4'b1110, 2'd0, 1'b0);
    check_output("entry_div1", led1, code1, step1, 4'b1110, 2'd0, 1'b0);

    // DIV=4 dwell including the 3->0 wrap; DIV=1 advances every edge
    for (int t = 1; t <= 25; t++) begin
      next_cycle();
      check_output($sformatf("scan4_t%0d", t), led4, code4, step4,
                   led_tab[(t / 4) % 4], 2'((t / 4) % 4), (t % 4) == 0);
      if (t <= 5) begin
        check_output($sformatf("scan1_t%0d", t), led1, code1, step1,
                     led_tab[t % 4], 2'(t % 4), 1'b1);
      end
    end

    // Now at index 2 with the prescaler at 1: drop to manual with SW=3
    apply_stimulus(1'b1, 1'b1, 1'b0, 2'd3);
    next_cycle();
    check_output("midscan_manual", led4, code4, step4, 4'b0111, 2'd3, 1'b0);
    check_output("midscan_manual_div1", led1, code1, step1, 4'b0111, 2'd3, 1'b0);

    for (int s = 0; s < 4; s++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 2'(s));
      next_cycle();
      exp_led = led_tab[s];
      check_output($sformatf("manual_sw%0d", s), led4, code4, step4, exp_led, 2'(s), 1'b0);
      vectors++;
      assert (encode4_2(led4) === 2'(s)) else begin
        miscompares++;
        $error("[TB] FAIL roundtrip_sw%0d: observed code=%0d, expected code=%0d", s, encode4_2(led4), s);
      end
    end

    // Return to scan restarts at index 0 with a fresh 4-cycle dwell
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd3);
    next_cycle();
    check_output("rescan_entry", led4, code4, step4, 4'b1110, 2'd0, 1'b0);
    scan_dwell4("rescan", 1, 12);

    apply_stimulus(1'b1, 1'b0, 1'b1, 2'd3);
    next_cycle();
    check_output("en_drop", led4, code4, step4, 4'b1111, 2'd0, 1'b0);
    check_output("en_drop_div1", led1, code1, step1, 4'b1111, 2'd0, 1'b0);

    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd3);
    next_cycle();
    check_output("reenable_entry", led4, code4, step4, 4'b1110, 2'd0, 1'b0);
    scan_dwell4("reenable", 1, 12);

    apply_stimulus(1'b0, 1'b1, 1'b1, 2'd2);
    next_cycle();
    check_output("midscan_reset", led4, code4, step4, 4'b1111, 2'd0, 1'b0);
    check_output("midscan_reset_div1", led1, code1, step1, 4'b1111, 2'd0, 1'b0);

    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd2);
    next_cycle();
    check_output("post_reset_entry", led4, code4, step4, 4'b1110, 2'd0, 1'b0);
    scan_dwell4("post_reset", 1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
